// File: rtl/spi_cfg_pkg.sv
// Shared widths, frame geometry and FSM state type for the SPI config receiver.
package spi_cfg_pkg;

    localparam int ADDR_W  = 4;
    localparam int DATA_W  = 12;
    localparam int FRAME_W = ADDR_W + DATA_W;
    localparam int BCNT_W  = 5;

    // Bit counter saturates here so over-long frames can never wrap back to a legal length
    localparam logic [BCNT_W-1:0] BCNT_MAX  = '1;
    localparam logic [BCNT_W-1:0] FRAME_LEN = BCNT_W'(FRAME_W);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/spi_cfg_regfile.sv
// Shadow register file: synchronous clear, one write port, registered read port.
// A read and a write to the same address in one cycle returns the old contents.
module spi_cfg_regfile
    import spi_cfg_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    // Storage array and read register, both cleared by reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 2**ADDR_W; i++) begin
                mem_q[i] <= '0;
            end
            rdata_q <= '0;
        end else begin
            if (we_i) begin
                mem_q[waddr_i] <= wdata_i;
            end
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/spi_cfg_rx.sv
// SPI configuration receiver: deserialises 16-bit {addr, data} frames framed by
// active-low spi_en, commits them to the shadow register file, counts committed
// frames and flags frames whose length is not exactly 16 bits.
module spi_cfg_rx
    import spi_cfg_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              clock_20,
    input  logic              reset,
    input  logic              spi_en,
    input  logic              spi_dat,
    input  logic [3:0]        nrg,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              frame_err,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic              cfg_done
);

    state_e              state_q, state_d;
    logic [FRAME_W-1:0]  sr_q, sr_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
    logic                wr_valid_q, wr_valid_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                frame_err_q, frame_err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                commit;

    // State, shift register, counters and output pulses
    always_ff @(posedge clock_20) begin
        if (reset) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            bcnt_q      <= '0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            frame_err_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            bcnt_q      <= bcnt_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            frame_err_q <= frame_err_d;
            cnt_q       <= cnt_d;
        end
    end

    // Next-state: first bit is taken on the same edge spi_en is first seen low;
    // the deselect edge decides commit versus error from the bit count
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        bcnt_d      = bcnt_q;
        wr_valid_d  = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frame_err_d = 1'b0;
        cnt_d       = cnt_q;
        commit      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!spi_en) begin
                    sr_d    = {{(FRAME_W-1){1'b0}}, spi_dat};
                    bcnt_d  = BCNT_W'(1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!spi_en) begin
                    sr_d = {sr_q[FRAME_W-2:0], spi_dat};
                    if (bcnt_q != BCNT_MAX) begin
                        bcnt_d = bcnt_q + BCNT_W'(1);
                    end
                end else begin
                    state_d = IDLE;
                    bcnt_d  = '0;
                    if (bcnt_q == FRAME_LEN) begin
                        commit     = 1'b1;
                        wr_valid_d = 1'b1;
                        wr_addr_d  = sr_q[FRAME_W-1:DATA_W];
                        wr_data_d  = sr_q[DATA_W-1:0];
                        if (cnt_q != '1) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    spi_cfg_regfile u_regfile (
        .clk_i   (clock_20),
        .rst_i   (reset),
        .we_i    (commit),
        .waddr_i (sr_q[FRAME_W-1:DATA_W]),
        .wdata_i (sr_q[DATA_W-1:0]),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    assign wr_valid  = wr_valid_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign frame_err = frame_err_q;
    assign frame_cnt = cnt_q;
    assign cfg_done  = (cnt_q >= CNT_W'(nrg));

endmodule
